led_share_arbiter: RTL
======================

Name: led_share_arbiter

Overview:
- Shares the eight PL user LEDs between NREQ on-chip requesters, e.g. debug monitors or status reporters.
- Uses round-robin arbitration with minimum and maximum hold times.
- With no grant active, the LEDs show a free-running heartbeat taken from bits [HB_SHIFT+7:HB_SHIFT] of an internal counter.
- Sits between the clocking block (clk_400_000, locked) and the PL_LED1..8 pins.

Parameters:
NREQ, 4, number of requesters (2..8)
HB_SHIFT, 24, LSB of the heartbeat byte within the internal 64-bit counter
MIN_HOLD, 400000, minimum grant length in cycles (1 ms at 400 MHz); must be >= 1
MAX_HOLD, 400000000, maximum grant length in cycles when another requester is pending; must be >= MIN_HOLD
HOLD_W, 32, width of the hold counter; must hold MAX_HOLD

Ports:
clk_400_000  in  1  system clock, 400 MHz
RESET  in  1  asynchronous reset, active-high
locked  in  1  clocking block locked; low acts as a synchronous clear
req  in  NREQ  per-requester request level
pattern  in  8*NREQ  LED byte for requester i, at bits [8i+7:8i]
gnt  out  NREQ  one-hot grant, registered
led  out  8  LED drive; led[0] maps to PL_LED1 and led[7] to PL_LED8
busy  out  1  high while in GRANT

Behaviour:
- Reset:
  - Applies when RESET is high (async) or locked is low (sync, next edge).
  - Results: state=IDLE, gnt=0, busy=0, led=0, heartbeat counter=0, hold counter=0, rr_ptr=0.
- Heartbeat counter:
  - 64-bit, increments by 1 every cycle out of reset and wraps modulo 2^64.
  - Keeps running in every state.
- All outputs are registered. led and gnt update on the same edge.
- States: IDLE, GRANT, GAP.
- IDLE:
  - led <= heartbeat bits [HB_SHIFT+7:HB_SHIFT]; gnt=0.
  - If any req bit is high, pick the first set bit scanning upward from rr_ptr with wrap (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - On the next edge: gnt <= onehot(winner), state <= GRANT, hold <= 1, busy <= 1.
  - Latency: req sampled at edge k gives gnt high after edge k+1.
- GRANT, owner w:
  - led <= pattern[w] every cycle. Pattern changes are visible one cycle later.
  - hold increments each cycle and saturates at MAX_HOLD.
  - Release when either condition holds:
    - hold >= MIN_HOLD and req[w]=0, or
    - hold >= MAX_HOLD and any req[j]=1 for j != w (preemption).
  - On release: gnt <= 0, busy <= 0, rr_ptr <= (w+1) mod NREQ, state <= GAP, led holds its last value.
  - If req[w] drops before MIN_HOLD, the grant is held to MIN_HOLD and led keeps following pattern[w].
  - If hold reaches MAX_HOLD with no other requester, the grant continues indefinitely while req[w] stays high.
- GAP:
  - Exactly one cycle with gnt=0 and led unchanged, then state <= IDLE.
  - Minimum spacing between two grants: release edge, GAP, IDLE arbitration edge, so gnt is low for 2 cycles.
- Fairness:
  - rr_ptr advances only on release.
  - A requester released while still requesting is served again only after every other pending requester has had a turn.
- Simultaneous events:
  - A req change in the same cycle as a release is evaluated at IDLE arbitration, not during GAP.
  - If RESET or !locked fires mid-GRANT, gnt drops as described under Reset, with no GAP, and rr_ptr returns to 0.
- gnt is always one-hot or zero; more than one bit set is a failure.

Test Plan:
1. RESET high, then low with locked=1 and req=0; use HB_SHIFT=2 for simulation. Expect led=0 during reset, then led = counter[9:2], incrementing every 4 cycles.
2. MIN_HOLD=4. req=0001, pattern0=8'hA5. Expect:
   - gnt=0001 two edges after req rises.
   - led=A5 from the same edge.
   - Dropping req0 on hold 2 keeps gnt until hold=4, then gnt=0 for 2 cycles, then led returns to the heartbeat.
3. MIN_HOLD=4, MAX_HOLD=16. req=1111 held constantly. Expect:
   - Grant order 0,1,2,3,0.
   - Each grant lasts exactly 16 cycles, separated by 2 idle-gnt cycles.
   - led follows the respective pattern.
4. rr_ptr=2 after a release; req=0101 simultaneously. Expect requester 2 granted first, then 0.
5. Mid-GRANT, deassert locked for 1 cycle. Expect gnt=0, led=0 and busy=0 on the next edge. The following arbitration restarts from rr_ptr=0.
6. req[1] alone with MAX_HOLD=16, held 100 cycles. Expect gnt=0010 continuous for 100+ cycles with no preemption and hold saturated at 16.

Source files
------------

// File: rtl/led_share_arbiter_if.sv
// Requester/LED bundle for the LED share arbiter.
// Requesters drive req/pattern; the arbiter drives gnt/led/busy.
interface led_share_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req;
   logic [8*NREQ-1:0] pattern;
   logic [NREQ-1:0]   gnt;
   logic [7:0]        led;
   logic              busy;

   modport master (
      output req, pattern,
      input  gnt, led, busy
   );

   modport slave (
      input  req, pattern,
      output gnt, led, busy
   );
endinterface

// File: rtl/led_share_arbiter.sv
// Round-robin sharing of the eight PL user LEDs between NREQ requesters.
// Heartbeat on the LEDs whenever nobody holds a grant.
module led_share_arbiter #(
   parameter int NREQ     = 4,
   parameter int HB_SHIFT = 24,
   parameter int MIN_HOLD = 400000,
   parameter int MAX_HOLD = 400000000,
   parameter int HOLD_W   = 32
) (
   input logic clk_400_000,
   input logic RESET,
   input logic locked,
   led_share_arbiter_if.slave bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [HOLD_W-1:0] MIN_H = HOLD_W'(MIN_HOLD);
   localparam logic [HOLD_W-1:0] MAX_H = HOLD_W'(MAX_HOLD);

   typedef enum logic [1:0] {IDLE, GRANT, GAP} state_t;

   state_t            state_q, state_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [7:0]        led_q, led_d;
   logic              busy_q, busy_d;
   logic [63:0]       cnt_q;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [PW-1:0]     rr_q, rr_d;
   logic [PW-1:0]     own_q, own_d;
   logic [NREQ-1:0]   req_q;

   logic [PW-1:0]     win;
   logic              found;
   logic              rel;
   logic [7:0]        pat_win;
   logic [7:0]        pat_own;

   // first requester at or above rr_q, wrapping
   always_comb begin
      int idx;
      idx   = 0;
      win   = '0;
      found = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_q) + k) % NREQ;
         if (!found && req_q[idx]) begin
            win   = PW'(idx);
            found = 1'b1;
         end
      end
   end

   assign pat_win = bus.pattern[8*win +: 8];
   assign pat_own = bus.pattern[8*own_q +: 8];

   assign rel = ((hold_q >= MIN_H) && !req_q[own_q]) ||
                ((hold_q >= MAX_H) && |(req_q & ~gnt_q));

   always_comb begin
      state_d = state_q;
      gnt_d   = gnt_q;
      led_d   = led_q;
      busy_d  = busy_q;
      hold_d  = hold_q;
      rr_d    = rr_q;
      own_d   = own_q;
      unique case (state_q)
         IDLE: begin
            led_d = cnt_q[HB_SHIFT +: 8];
            gnt_d = '0;
            if (found) begin
               state_d = GRANT;
               gnt_d   = NREQ'(1) << win;
               own_d   = win;
               hold_d  = HOLD_W'(1);
               busy_d  = 1'b1;
               led_d   = pat_win;
            end
         end
         GRANT: begin
            if (rel) begin
               state_d = GAP;
               gnt_d   = '0;
               busy_d  = 1'b0;
               rr_d    = (own_q == PW'(NREQ-1)) ? '0 : own_q + 1'b1;
            end else begin
               led_d  = pat_own;
               hold_d = (hold_q >= MAX_H) ? hold_q : hold_q + 1'b1;
            end
         end
         GAP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
            gnt_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_400_000 or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
         rr_q    <= '0;
         own_q   <= '0;
         req_q   <= '0;
      end else if (!locked) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         led_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
         hold_q  <= '0;
         rr_q    <= '0;
         own_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         led_q   <= led_d;
         busy_q  <= busy_d;
         cnt_q   <= cnt_q + 64'd1;
         hold_q  <= hold_d;
         rr_q    <= rr_d;
         own_q   <= own_d;
         req_q   <= bus.req;
      end
   end

   assign bus.gnt  = gnt_q;
   assign bus.led  = led_q;
   assign bus.busy = busy_q;
endmodule
